// File: rtl/cp0_exc_seq.sv
// CP0 write sequencer: turns exception entry, ERET and MTC0 requests into a
// short series of single-register CP0 writes with a DONE pulse on the last one.
module cp0_exc_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EXC_REQ,
    input  logic [4:0]  EXC_CODE,
    input  logic [31:0] EXC_PC,
    input  logic        ERET_REQ,
    input  logic        MTC0_REQ,
    input  logic [31:0] MTC0_DATA,
    input  logic [31:0] STATUS_IN,
    output logic        MUXT_CP0_W_STATUS,
    output logic        MUXT_CP0_W_CAUSE,
    output logic        MUXT_CP0_W_EPC,
    output logic        MUXT_CP0_W_RD,
    output logic        CP0_WE,
    output logic [31:0] CP0_W_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        JUMP_HANDLER,
    output logic        JUMP_EPC
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EX_STATUS = 3'd1,
        EX_CAUSE  = 3'd2,
        EX_EPC    = 3'd3,
        ER_STATUS = 3'd4,
        MT_WRITE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mt_data_q, mt_data_d;
    logic        accept;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            status_q  <= '0;
            code_q    <= '0;
            pc_q      <= '0;
            mt_data_q <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            mt_data_q <= mt_data_d;
        end
    end

    // Requests are only looked at in IDLE; anything seen while busy is dropped.
    always_comb begin
        accept    = (state_q == IDLE) && (EXC_REQ || ERET_REQ || MTC0_REQ);
        state_d   = state_q;
        status_d  = status_q;
        code_d    = code_q;
        pc_d      = pc_q;
        mt_data_d = mt_data_q;
        if (accept) begin
            status_d  = STATUS_IN;
            code_d    = EXC_CODE;
            pc_d      = EXC_PC;
            mt_data_d = MTC0_DATA;
        end
        case (state_q)
            IDLE: begin
                if (EXC_REQ)       state_d = EX_STATUS;
                else if (ERET_REQ) state_d = ER_STATUS;
                else if (MTC0_REQ) state_d = MT_WRITE;
            end
            EX_STATUS: state_d = EX_CAUSE;
            EX_CAUSE:  state_d = EX_EPC;
            EX_EPC:    state_d = IDLE;
            ER_STATUS: state_d = IDLE;
            MT_WRITE:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        MUXT_CP0_W_STATUS = 1'b0;
        MUXT_CP0_W_CAUSE  = 1'b0;
        MUXT_CP0_W_EPC    = 1'b0;
        MUXT_CP0_W_RD     = 1'b0;
        CP0_WE            = 1'b0;
        CP0_W_DATA        = '0;
        BUSY              = (state_q != IDLE);
        DONE              = 1'b0;
        JUMP_HANDLER      = 1'b0;
        JUMP_EPC          = 1'b0;
        case (state_q)
            EX_STATUS: begin
                MUXT_CP0_W_STATUS = 1'b1;
                CP0_WE            = 1'b1;
                CP0_W_DATA        = {status_q[26:0], 5'b0};
            end
            EX_CAUSE: begin
                MUXT_CP0_W_CAUSE = 1'b1;
                CP0_WE           = 1'b1;
                CP0_W_DATA       = {25'b0, code_q, 2'b00};
            end
            EX_EPC: begin
                MUXT_CP0_W_EPC = 1'b1;
                CP0_WE         = 1'b1;
                CP0_W_DATA     = pc_q;
                DONE           = 1'b1;
                JUMP_HANDLER   = 1'b1;
            end
            ER_STATUS: begin
                MUXT_CP0_W_STATUS = 1'b1;
                CP0_WE            = 1'b1;
                CP0_W_DATA        = {5'b0, status_q[31:5]};
                DONE              = 1'b1;
                JUMP_EPC          = 1'b1;
            end
            MT_WRITE: begin
                MUXT_CP0_W_RD = 1'b1;
                CP0_WE        = 1'b1;
                CP0_W_DATA    = mt_data_q;
                DONE          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed bench for cp0_exc_seq: each task drives one scenario and checks the
// control bundle and write data one cycle at a time.
module tb_cp0_exc_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EXC_REQ = 1'b0;
    logic [4:0]  EXC_CODE = '0;
    logic [31:0] EXC_PC = '0;
    logic        ERET_REQ = 1'b0;
    logic        MTC0_REQ = 1'b0;
    logic [31:0] MTC0_DATA = '0;
    logic [31:0] STATUS_IN = '0;
    logic        MUXT_CP0_W_STATUS, MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC, MUXT_CP0_W_RD;
    logic        CP0_WE, BUSY, DONE, JUMP_HANDLER, JUMP_EPC;
    logic [31:0] CP0_W_DATA;

    int errors = 0;
    int checks = 0;

    // {STATUS, CAUSE, EPC, RD, WE, BUSY, DONE, JUMP_HANDLER, JUMP_EPC}
    logic [8:0] ctl;
    assign ctl = {MUXT_CP0_W_STATUS, MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC, MUXT_CP0_W_RD,
                  CP0_WE, BUSY, DONE, JUMP_HANDLER, JUMP_EPC};

    localparam logic [8:0] C_IDLE = 9'b0000_0000_0;
    localparam logic [8:0] C_EXS  = 9'b1000_1100_0;
    localparam logic [8:0] C_EXC  = 9'b0100_1100_0;
    localparam logic [8:0] C_EXE  = 9'b0010_1111_0;
    localparam logic [8:0] C_ERS  = 9'b1000_1110_1;
    localparam logic [8:0] C_MT   = 9'b0001_1110_0;

    cp0_exc_seq dut (
        .CLK(CLK), .RST_N(RST_N), .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE),
        .EXC_PC(EXC_PC), .ERET_REQ(ERET_REQ), .MTC0_REQ(MTC0_REQ),
        .MTC0_DATA(MTC0_DATA), .STATUS_IN(STATUS_IN),
        .MUXT_CP0_W_STATUS(MUXT_CP0_W_STATUS), .MUXT_CP0_W_CAUSE(MUXT_CP0_W_CAUSE),
        .MUXT_CP0_W_EPC(MUXT_CP0_W_EPC), .MUXT_CP0_W_RD(MUXT_CP0_W_RD),
        .CP0_WE(CP0_WE), .CP0_W_DATA(CP0_W_DATA), .BUSY(BUSY), .DONE(DONE),
        .JUMP_HANDLER(JUMP_HANDLER), .JUMP_EPC(JUMP_EPC)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        EXC_REQ = 1'b1;
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE);
        end
        checks++;
        if (CP0_W_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=%h", CP0_W_DATA, 32'h0);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_override_req got=%b exp=%b", ctl, C_IDLE);
        end
        EXC_REQ = 1'b0;
        RST_N = 1'b1;
        tick();
        $display("reset: ctl=%b data=%h", ctl, CP0_W_DATA);
    endtask

    task automatic test_exc_entry;
        EXC_REQ = 1'b1; EXC_CODE = 5'd8; EXC_PC = 32'h0040_0010; STATUS_IN = 32'h0000_001F;
        tick();
        EXC_REQ = 1'b0;
        checks++;
        if (ctl !== C_EXS || CP0_W_DATA !== 32'h0000_03E0) begin
            errors++;
            $display("FAIL exc_status got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXS, 32'h3E0);
        end
        tick();
        checks++;
        if (ctl !== C_EXC || CP0_W_DATA !== 32'h0000_0020) begin
            errors++;
            $display("FAIL exc_cause got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXC, 32'h20);
        end
        tick();
        checks++;
        if (ctl !== C_EXE || CP0_W_DATA !== 32'h0040_0010) begin
            errors++;
            $display("FAIL exc_epc got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXE, 32'h0040_0010);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE || CP0_W_DATA !== 32'h0) begin
            errors++;
            $display("FAIL exc_idle got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_IDLE, 32'h0);
        end
        $display("exc_entry: code=8 pc=00400010 status=0000001f done");
    endtask

    task automatic test_eret;
        ERET_REQ = 1'b1; STATUS_IN = 32'h0000_03E0;
        tick();
        ERET_REQ = 1'b0;
        checks++;
        if (ctl !== C_ERS || CP0_W_DATA !== 32'h0000_001F) begin
            errors++;
            $display("FAIL eret_status got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_ERS, 32'h1F);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL eret_idle got=%b exp=%b", ctl, C_IDLE);
        end
        $display("eret: status=000003e0 done");
    endtask

    task automatic test_mtc0;
        MTC0_REQ = 1'b1; MTC0_DATA = 32'hDEAD_BEEF;
        tick();
        MTC0_REQ = 1'b0;
        checks++;
        if (ctl !== C_MT || CP0_W_DATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mtc0_write got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_MT, 32'hDEAD_BEEF);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL mtc0_idle got=%b exp=%b", ctl, C_IDLE);
        end
        $display("mtc0: data=deadbeef done");
    endtask

    task automatic test_priority;
        EXC_REQ = 1'b1; ERET_REQ = 1'b1; MTC0_REQ = 1'b1;
        EXC_CODE = 5'd9; EXC_PC = 32'h0000_1000; STATUS_IN = 32'h0000_0001;
        MTC0_DATA = 32'h1111_2222;
        tick();
        EXC_REQ = 1'b0; ERET_REQ = 1'b0; MTC0_REQ = 1'b0;
        checks++;
        if (ctl !== C_EXS || CP0_W_DATA !== 32'h0000_0020) begin
            errors++;
            $display("FAIL prio_status got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXS, 32'h20);
        end
        tick();
        MTC0_REQ = 1'b1;
        checks++;
        if (ctl !== C_EXC || CP0_W_DATA !== 32'h0000_0024) begin
            errors++;
            $display("FAIL prio_cause got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXC, 32'h24);
        end
        tick();
        MTC0_REQ = 1'b0;
        checks++;
        if (ctl !== C_EXE || CP0_W_DATA !== 32'h0000_1000) begin
            errors++;
            $display("FAIL prio_epc got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXE, 32'h1000);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL prio_no_rd got=%b exp=%b", ctl, C_IDLE);
        end
        $display("priority: exc won, busy mtc0 dropped");
    endtask

    task automatic test_reset_mid;
        EXC_REQ = 1'b1; EXC_CODE = 5'd10; EXC_PC = 32'h0000_2000; STATUS_IN = 32'h3;
        tick();
        EXC_REQ = 1'b0;
        tick();
        checks++;
        if (ctl !== C_EXC) begin
            errors++;
            $display("FAIL rstmid_cause got=%b exp=%b", ctl, C_EXC);
        end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        checks++;
        if (ctl !== C_IDLE || CP0_W_DATA !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_abort got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_IDLE, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ctl !== C_IDLE) begin
                errors++;
                $display("FAIL rstmid_quiet[%0d] got=%b exp=%b", i, ctl, C_IDLE);
            end
        end
        $display("reset_mid: sequence aborted");
    endtask

    task automatic test_capture;
        EXC_REQ = 1'b1; EXC_CODE = 5'd31; EXC_PC = 32'h1234_5678; STATUS_IN = 32'hFFFF_FFFF;
        tick();
        EXC_REQ = 1'b0; EXC_CODE = 5'd0; EXC_PC = 32'hFFFF_FFFF; STATUS_IN = 32'h0;
        checks++;
        if (ctl !== C_EXS || CP0_W_DATA !== 32'hFFFF_FFE0) begin
            errors++;
            $display("FAIL cap_status got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXS, 32'hFFFF_FFE0);
        end
        tick();
        checks++;
        if (ctl !== C_EXC || CP0_W_DATA !== 32'h0000_007C) begin
            errors++;
            $display("FAIL cap_cause got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXC, 32'h7C);
        end
        tick();
        checks++;
        if (ctl !== C_EXE || CP0_W_DATA !== 32'h1234_5678) begin
            errors++;
            $display("FAIL cap_epc got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_EXE, 32'h1234_5678);
        end
        tick();
        $display("capture: inputs changed after acceptance");
    endtask

    task automatic test_back_to_back;
        MTC0_REQ = 1'b1; MTC0_DATA = 32'hAAAA_0001;
        tick();
        MTC0_DATA = 32'hBBBB_0002;
        checks++;
        if (ctl !== C_MT || CP0_W_DATA !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL b2b_first got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_MT, 32'hAAAA_0001);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL b2b_gap got=%b exp=%b", ctl, C_IDLE);
        end
        tick();
        MTC0_REQ = 1'b0;
        checks++;
        if (ctl !== C_MT || CP0_W_DATA !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL b2b_second got=%b/%h exp=%b/%h", ctl, CP0_W_DATA, C_MT, 32'hBBBB_0002);
        end
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL b2b_idle got=%b exp=%b", ctl, C_IDLE);
        end
        $display("back_to_back: held mtc0 re-accepted after idle cycle");
    endtask

    initial begin
        test_reset();
        test_exc_entry();
        test_eret();
        test_mtc0();
        test_priority();
        test_reset_mid();
        test_capture();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
